// File: rtl/sd_cmd_tx_if.sv
// SD command transmitter bus: request side from the host sequencer, pad/status side back.
// Optional crc_inject signal exists only when SD_CMD_TX_CRC_INJECT_EN is defined.
interface sd_cmd_tx_if;
  logic        start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
`ifdef SD_CMD_TX_CRC_INJECT_EN
  logic        crc_inject;
`endif
  logic        sd_cmd_out;
  logic        sd_cmd_oe;
  logic        busy;
  logic        done;

`ifdef SD_CMD_TX_CRC_INJECT_EN
  modport master (
    output start, cmd_index, cmd_arg, crc_inject,
    input  sd_cmd_out, sd_cmd_oe, busy, done
  );
  modport slave (
    input  start, cmd_index, cmd_arg, crc_inject,
    output sd_cmd_out, sd_cmd_oe, busy, done
  );
`else
  modport master (
    output start, cmd_index, cmd_arg,
    input  sd_cmd_out, sd_cmd_oe, busy, done
  );
  modport slave (
    input  start, cmd_index, cmd_arg,
    output sd_cmd_out, sd_cmd_oe, busy, done
  );
`endif
endinterface

// File: rtl/sd_cmd_tx.sv
// SD CMD-line transmitter: shifts out a 48-bit command frame (start, dir, index, arg,
// CRC7, end) MSB first, then releases the line for IDLE_CYCLES before the next command.
// Optional macro SD_CMD_TX_CRC_INJECT_EN adds crc_inject, which flips CRC bit 0.
module sd_cmd_tx #(
  parameter int unsigned IDLE_CYCLES = 8
) (
  input logic         sd_clk,
  input logic         reset,
  sd_cmd_tx_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StSend, StCrc, StStop, StGap} state_e;

  localparam logic [7:0] GapLast = 8'(IDLE_CYCLES);

  state_e      state_q;
  logic [39:0] shift_q;
  logic [6:0]  crc_q;
  logic [7:0]  cnt_q;
  logic        inject_q;
  logic        out_q;
  logic        oe_q;
  logic        busy_q;
  logic        done_q;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // Frame FSM; outputs are registered and hold the value for the bit being driven.
  // The accepting edge already drives the start bit, so SEND covers the remaining 39 bits.
  always_ff @(posedge sd_clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      crc_q    <= '0;
      cnt_q    <= '0;
      inject_q <= 1'b0;
      out_q    <= 1'b1;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          out_q  <= 1'b1;
          oe_q   <= 1'b0;
          busy_q <= 1'b0;
          if (bus.start) begin
            // Start bit goes out now; remaining bits left-aligned behind it.
            out_q   <= 1'b0;
            oe_q    <= 1'b1;
            busy_q  <= 1'b1;
            shift_q <= {1'b1, bus.cmd_index, bus.cmd_arg, 1'b0};
            crc_q   <= '0;  // CRC of a single 0 bit from a zero seed stays zero
            cnt_q   <= 8'd1;
`ifdef SD_CMD_TX_CRC_INJECT_EN
            inject_q <= bus.crc_inject;
`else
            inject_q <= 1'b0;
`endif
            state_q <= StSend;
          end
        end
        StSend: begin
          out_q   <= shift_q[39];
          shift_q <= {shift_q[38:0], 1'b0};
          if (cnt_q == 8'd39) begin
            crc_q   <= crc7_step(crc_q, shift_q[39]) ^ {6'd0, inject_q};
            cnt_q   <= '0;
            state_q <= StCrc;
          end else begin
            crc_q <= crc7_step(crc_q, shift_q[39]);
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StCrc: begin
          out_q <= crc_q[6];
          crc_q <= {crc_q[5:0], 1'b0};
          if (cnt_q == 8'd6) begin
            cnt_q   <= '0;
            state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StStop: begin
          out_q   <= 1'b1;
          oe_q    <= 1'b1;
          cnt_q   <= '0;
          state_q <= StGap;
        end
        StGap: begin
          // IDLE_CYCLES released cycles, then one more edge that signals completion.
          out_q <= 1'b1;
          oe_q  <= 1'b0;
          if (cnt_q == GapLast) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.sd_cmd_out = out_q;
  assign bus.sd_cmd_oe  = oe_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
